// File: rtl/nios_core_i2c_master.sv
// Avalon-MM I2C byte master: START / byte / STOP sequencing.
// Open-drain pads: an *_oe of 1 pulls the line low, 0 releases it.
module nios_core_i2c_master #(
    parameter int unsigned CLK_DIV = 124
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_in,
    output logic        irq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_STOP,
        S_FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q;
    logic [7:0]  tx_byte_q;
    logic [7:0]  rx_byte_q;
    logic        busy_q;
    logic        done_q;
    logic        rx_nack_q;
    logic        irq_en_q;
    logic        stop_q, stop_d;
    logic        byte_q, byte_d;
    logic        rd_q, rd_d;
    logic        mack_n_q, mack_n_d;
    logic        scl_oe_q;
    logic        sda_oe_q;
    logic        enter;
    logic        tx_oe;
    logic        wr_en;
    logic        wr_data;
    logic        wr_cmd;
    logic        wr_stat;
    logic        wr_div;
    logic        unused_wd;

    assign wr_en   = chipselect & ~write_n;
    assign wr_data = wr_en & (address == 2'd0) & ~busy_q;
    assign wr_cmd  = wr_en & (address == 2'd1) & ~busy_q
                   & (|writedata[3:0]);
    assign wr_stat = wr_en & (address == 2'd2);
    assign wr_div  = wr_en & (address == 2'd3) & ~busy_q;

    assign unused_wd = ^writedata[31:16];

    assign scl_oe = scl_oe_q;
    assign sda_oe = sda_oe_q;
    assign irq    = done_q & irq_en_q;

    // Register read mux, zero wait states.
    always_comb begin
        readdata = 32'd0;
        unique case (address)
            2'd0: readdata = {24'd0, rx_byte_q};
            2'd1: readdata = 32'd0;
            2'd2: readdata = {28'd0, irq_en_q, done_q, rx_nack_q, busy_q};
            2'd3: readdata = {16'd0, div_q};
        endcase
    end

    // Command flags: taken from the bus on the accepting edge, held after.
    always_comb begin
        stop_d   = stop_q;
        byte_d   = byte_q;
        rd_d     = rd_q;
        mack_n_d = mack_n_q;
        if (wr_cmd) begin
            stop_d   = writedata[1];
            byte_d   = writedata[2] | writedata[3];
            rd_d     = writedata[3] & ~writedata[2];
            mack_n_d = writedata[4];
        end
    end

    // SDA drive for the BIT quarter 0 being entered (data, ack, or release).
    always_comb begin
        tx_oe = 1'b0;
        if (bit_d == 4'd8)
            tx_oe = rd_d & ~mack_n_d;
        else if (!rd_d)
            tx_oe = ~tx_byte_q[3'd7 - bit_d[2:0]];
    end

    // Next phase/quarter/bit location; enter flags a quarter boundary.
    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        enter   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (wr_cmd) begin
                    enter = 1'b1;
                    qtr_d = 2'd0;
                    bit_d = 4'd0;
                    cnt_d = div_q;
                    if (writedata[0])
                        state_d = S_START;
                    else if (|writedata[3:2])
                        state_d = S_BIT;
                    else
                        state_d = S_STOP;
                end
            end
            S_START, S_BIT, S_STOP: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    cnt_d = div_q;
                    enter = 1'b1;
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        if (state_q == S_BIT && bit_q != 4'd8) begin
                            bit_d = bit_q + 4'd1;
                        end else begin
                            bit_d = 4'd0;
                            if (state_q == S_START && byte_d)
                                state_d = S_BIT;
                            else if (state_q != S_STOP && stop_d)
                                state_d = S_STOP;
                            else
                                state_d = S_FINISH;
                        end
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control FSM, register file and registered pad drives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            qtr_q     <= 2'd0;
            bit_q     <= 4'd0;
            cnt_q     <= 16'd0;
            div_q     <= 16'(CLK_DIV);
            tx_byte_q <= 8'd0;
            rx_byte_q <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_nack_q <= 1'b0;
            irq_en_q  <= 1'b0;
            stop_q    <= 1'b0;
            byte_q    <= 1'b0;
            rd_q      <= 1'b0;
            mack_n_q  <= 1'b0;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            qtr_q    <= qtr_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            stop_q   <= stop_d;
            byte_q   <= byte_d;
            rd_q     <= rd_d;
            mack_n_q <= mack_n_d;
            if (wr_data)
                tx_byte_q <= writedata[7:0];
            if (wr_div)
                div_q <= writedata[15:0];
            if (wr_stat)
                irq_en_q <= writedata[3];
            if (wr_stat && writedata[2])
                done_q <= 1'b0;
            if (wr_cmd)
                busy_q <= 1'b1;
            if (state_q == S_FINISH) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
            if (enter) begin
                case (state_d)
                    S_START: begin
                        case (qtr_d)
                            2'd0: begin
                                scl_oe_q <= 1'b0;
                                sda_oe_q <= 1'b0;
                            end
                            2'd2: sda_oe_q <= 1'b1;
                            2'd3: scl_oe_q <= 1'b1;
                            default: ;
                        endcase
                    end
                    S_BIT: begin
                        case (qtr_d)
                            2'd0: begin
                                scl_oe_q <= 1'b1;
                                sda_oe_q <= tx_oe;
                            end
                            2'd1: scl_oe_q <= 1'b0;
                            2'd2: begin
                                if (bit_d == 4'd8) begin
                                    if (!rd_q)
                                        rx_nack_q <= sda_in;
                                end else if (rd_q) begin
                                    rx_byte_q <= {rx_byte_q[6:0], sda_in};
                                end
                            end
                            2'd3: scl_oe_q <= 1'b1;
                        endcase
                    end
                    S_STOP: begin
                        case (qtr_d)
                            2'd0: sda_oe_q <= 1'b1;
                            2'd1: scl_oe_q <= 1'b0;
                            2'd2: sda_oe_q <= 1'b0;
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nios_core_i2c_master.sv
// Bench for nios_core_i2c_master: directed register/bus vectors,
// scoreboard queue of expected values checked by monitor processes.
module tb_nios_core_i2c_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        scl_oe;
    logic        sda_oe;
    logic        sda_in;
    logic        irq;

    always #5 clk = ~clk;

    nios_core_i2c_master dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe),
        .sda_in     (sda_in),
        .irq        (irq)
    );

    // Slave model: pattern bit per SCL-low slot, 1 = release.
    logic [8:0] pat = 9'h1FF;
    int         slot = 99;
    logic       slave_low;

    always @(posedge scl_oe) slot++;

    assign slave_low = (slot >= 0 && slot < 9) ? ~pat[8 - slot] : 1'b0;
    assign sda_in    = ~(sda_oe | slave_low);

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    logic        bits_q[$];
    event        obs_ev;
    int          obs_cnt;
    int          checks = 0;
    int          fails  = 0;
    exp_t        m_e;
    logic [31:0] m_act;
    logic        m_bit;

    // Register/pin monitor: pops one expectation per observation.
    always begin
        @(obs_ev);
        m_e = sb.pop_front();
        case (m_e.kind)
            0:       m_act = readdata;
            1:       m_act = {30'd0, scl_oe, sda_oe};
            2:       m_act = {31'd0, irq};
            default: m_act = obs_cnt;
        endcase
        checks++;
        if (m_act !== m_e.val) begin
            fails++;
            $display("FAIL %s: got %0h want %0h",
                     m_e.name, m_act, m_e.val);
        end
    end

    // Line monitor: master SDA level at each SCL rising edge.
    always begin
        @(negedge scl_oe);
        @(negedge clk);
        if (bits_q.size() > 0) begin
            m_bit = bits_q.pop_front();
            checks++;
            if (~sda_oe !== m_bit) begin
                fails++;
                $display("FAIL sda_bit: got %0b want %0b", ~sda_oe, m_bit);
            end
        end
    end

    task automatic check(input string n, input int k,
                         input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
        ->obs_ev;
        #1;
    endtask

    task automatic chk_rd(input logic [1:0] a, input logic [31:0] v,
                          input string n);
        @(negedge clk);
        address = a;
        #1;
        check(n, 0, v);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic push_bits(input logic [8:0] v);
        for (int i = 8; i >= 0; i--) bits_q.push_back(v[i]);
    endtask

    task automatic wait_idle(output int n);
        address = 2'd2;
        #1;
        n = 0;
        while (readdata[0] === 1'b1 && n < 4000) begin
            n++;
            @(negedge clk);
            #1;
        end
        if (n >= 4000) begin
            fails++;
            $display("FAIL busy_timeout: got %0d want <4000", n);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_pins", 1, 32'd0);
        reset_n = 1'b1;
        chk_rd(2'd3, 32'd124, "rst_div");
        chk_rd(2'd2, 32'd0, "rst_status");
        chk_rd(2'd0, 32'd0, "rst_data");
        check("rst_irq", 2, 32'd0);

        // Write 0xA5 with START/STOP at DIV=1, slave ACKs.
        wr(2'd3, 32'd1);
        wr(2'd0, 32'hA5);
        pat = 9'h1FE;
        slot = -1;
        push_bits({8'hA5, 1'b1});
        wr(2'd1, 32'h07);
        wait_idle(n);
        obs_cnt = n;
        check("wr_busy_cycles", 3, 32'd89);
        chk_rd(2'd2, 32'h4, "wr_status");
        check("wr_pins", 1, 32'd0);

        // Read 0x3C at DIV=0, master NACKs, no START/STOP.
        wr(2'd3, 32'd0);
        pat = {8'h3C, 1'b1};
        slot = -1;
        push_bits(9'h1FF);
        wr(2'd1, 32'h18);
        wait_idle(n);
        obs_cnt = n;
        check("rd_busy_cycles", 3, 32'd37);
        chk_rd(2'd0, 32'h3C, "rd_data");
        chk_rd(2'd2, 32'h4, "rd_status");
        check("rd_scl_held", 1, 32'd2);

        // Write with NACK, then interrupt enable and done clear.
        wr(2'd2, 32'h4);
        chk_rd(2'd2, 32'h0, "done_clr");
        wr(2'd0, 32'h5A);
        pat = 9'h1FF;
        slot = -1;
        wr(2'd1, 32'h07);
        wait_idle(n);
        obs_cnt = n;
        check("nack_busy_cycles", 3, 32'd45);
        chk_rd(2'd2, 32'h6, "nack_status");
        check("irq_off", 2, 32'd0);
        wr(2'd2, 32'h8);
        chk_rd(2'd2, 32'hE, "irq_en_status");
        check("irq_on", 2, 32'd1);
        wr(2'd2, 32'hC);
        chk_rd(2'd2, 32'hA, "irq_clr_status");
        check("irq_cleared", 2, 32'd0);

        // Writes while busy must not disturb the transfer.
        wr(2'd0, 32'h11);
        pat = 9'h1FE;
        slot = -1;
        push_bits({8'h11, 1'b1});
        wr(2'd1, 32'h07);
        wr(2'd0, 32'hFF);
        wr(2'd3, 32'd5);
        wr(2'd1, 32'h18);
        wait_idle(n);
        chk_rd(2'd3, 32'd0, "busy_div_kept");
        chk_rd(2'd2, 32'hC, "busy_status");
        check("busy_irq", 2, 32'd1);
        check("busy_pins", 1, 32'd0);
        repeat (5) @(negedge clk);
        chk_rd(2'd2, 32'hC, "busy_no_requeue");

        // Empty command is ignored.
        wr(2'd2, 32'h4);
        wr(2'd1, 32'h00);
        chk_rd(2'd2, 32'h0, "cmd_zero");

        // Reset in the middle of bit 0 of a byte.
        wr(2'd3, 32'd3);
        wr(2'd0, 32'h0F);
        wr(2'd1, 32'h07);
        repeat (29) @(negedge clk);
        #1;
        check("mid_pins", 1, 32'd3);
        reset_n = 1'b0;
        #1;
        check("async_rst_pins", 1, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        chk_rd(2'd3, 32'd124, "rst2_div");
        chk_rd(2'd2, 32'd0, "rst2_status");
        chk_rd(2'd0, 32'd0, "rst2_data");
        check("rst2_irq", 2, 32'd0);
        check("rst2_pins", 1, 32'd0);

        repeat (4) @(negedge clk);
        checks++;
        if (bits_q.size() != 0) begin
            fails++;
            $display("FAIL sda_bits_left: got %0d want 0", bits_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
